// File: rtl/time_stamp_sync_ctrl_pkg.sv
// Shared widths, the PPS/host load sequencer states and a seconds-to-timestamp helper.
// Timestamp layout is {sec[63:32], frac[31:0]} with 4295 frac ticks per microsecond.
package time_sync_pkg;

    localparam int FRAC_PER_US = 4295;
    localparam int TS_W        = 64;
    localparam int SEC_W       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LOAD  = 2'd2
    } sync_state_t;

    function automatic logic [TS_W-1:0] sec_to_ts(input logic [SEC_W-1:0] sec);
        return {sec, {(TS_W-SEC_W){1'b0}}};
    endfunction

endpackage

// File: rtl/time_stamp_sync_ctrl_pps_edge_sync.sv
// Raw PPS into the core clock domain: 2-FF synchroniser, then a registered rising-edge pulse.
// Latency: o_pps_edge is high for one cycle, three cycles after the raw edge; no backpressure.
module pps_edge_sync (
    input  logic i_clk_50m,
    input  logic i_rst_n,
    input  logic i_pps,
    output logic o_pps_edge
);

    logic meta_q;
    logic sync_q;
    logic dly_q;
    logic edge_q;

    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta_q <= i_pps;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            edge_q <= sync_q & ~dly_q;
        end
    end

    assign o_pps_edge = edge_q;

endmodule

// File: rtl/time_stamp_sync_ctrl.sv
// Arbitrates PPS-aligned and host loads of time_stamp and runs the PPS lock/loss watchdog.
// Latency: all outputs registered, strobe 1 cycle after grant; host waits one cycle when PPS load wins.
module time_stamp_sync_ctrl
    import time_sync_pkg::*;
#(
    parameter int unsigned PPS_TIMEOUT_CYC = 75_000_000,
    parameter int unsigned PPS_MIN_CYC     = 45_000_000,
    parameter int unsigned LOCK_CNT        = 3,
    parameter int unsigned SEC_OFFSET      = 1
) (
    input  logic              i_clk_50m,
    input  logic              i_rst_n,
    input  logic              i_host_set_req,
    input  logic [TS_W-1:0]   i_host_set_val,
    output logic              o_host_set_ack,
    input  logic              i_pps,
    input  logic              i_pps_sec_vld,
    input  logic [SEC_W-1:0]  i_pps_sec,
    input  logic              i_pps_en,
    output logic              o_time_stamp_sig,
    output logic [TS_W-1:0]   o_time_stamp_set,
    output logic              o_sync_lock,
    output logic              o_pps_lost,
    output logic [7:0]        o_glitch_cnt
);

    localparam int GAP_W  = $clog2(PPS_TIMEOUT_CYC + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [GAP_W-1:0]  GAP_MIN  = GAP_W'(PPS_MIN_CYC);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(PPS_TIMEOUT_CYC);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

    logic              pps_edge;
    logic              edge_ok, edge_bad, timeout, pps_load;

    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [7:0]        glitch_q, glitch_d;
    logic              first_q, first_d;
    logic              lock_q, lock_d;
    logic              lost_q, lost_d;
    sync_state_t       state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic              sig_q, sig_d;
    logic              ack_q, ack_d;
    logic [TS_W-1:0]   set_q, set_d;

    pps_edge_sync u_pps_edge_sync (
        .i_clk_50m  (i_clk_50m),
        .i_rst_n    (i_rst_n),
        .i_pps      (i_pps),
        .o_pps_edge (pps_edge)
    );

    // first_q: no reference edge yet (after reset or loss), so any edge is trusted.
    always_comb begin
        edge_ok  = pps_edge && (first_q || (gap_q >= GAP_MIN));
        edge_bad = pps_edge && !edge_ok;
        timeout  = !edge_ok && (gap_q == GAP_MAX - 1'b1);

        gap_d    = gap_q;
        glitch_d = glitch_q;
        good_d   = good_q;
        first_d  = first_q;
        lock_d   = lock_q;
        lost_d   = lost_q;

        if (edge_ok) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end

        if (edge_bad && (glitch_q != 8'hFF)) begin
            glitch_d = glitch_q + 8'd1;
        end

        if (timeout) begin
            lost_d  = 1'b1;
            lock_d  = 1'b0;
            good_d  = '0;
            first_d = 1'b1;
        end else begin
            if (good_q == GOOD_MAX) begin
                lock_d = 1'b1;
            end
            if (edge_ok) begin
                lost_d  = 1'b0;
                first_d = 1'b0;
                if (good_q != GOOD_MAX) begin
                    good_d = good_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sec_d    = sec_q;
        pps_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_pps_sec_vld && i_pps_en) begin
                    sec_d   = i_pps_sec + SEC_W'(SEC_OFFSET);
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!i_pps_en) begin
                    state_d = IDLE;
                end else if (edge_ok) begin
                    pps_load = 1'b1;
                    state_d  = LOAD;
                end else if (timeout) begin
                    state_d = IDLE;
                end else if (i_pps_sec_vld) begin
                    sec_d = i_pps_sec + SEC_W'(SEC_OFFSET);
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // PPS load wins; an un-acked host request simply retries next cycle.
        sig_d = pps_load || i_host_set_req;
        ack_d = i_host_set_req && !pps_load;
        if (pps_load) begin
            set_d = sec_to_ts(sec_q);
        end else if (i_host_set_req) begin
            set_d = i_host_set_val;
        end else begin
            set_d = '0;
        end
    end

    always_ff @(posedge i_clk_50m) begin
        if (!i_rst_n) begin
            gap_q    <= '0;
            good_q   <= '0;
            glitch_q <= '0;
            first_q  <= 1'b1;
            lock_q   <= 1'b0;
            lost_q   <= 1'b0;
            state_q  <= IDLE;
            sec_q    <= '0;
            sig_q    <= 1'b0;
            ack_q    <= 1'b0;
            set_q    <= '0;
        end else begin
            gap_q    <= gap_d;
            good_q   <= good_d;
            glitch_q <= glitch_d;
            first_q  <= first_d;
            lock_q   <= lock_d;
            lost_q   <= lost_d;
            state_q  <= state_d;
            sec_q    <= sec_d;
            sig_q    <= sig_d;
            ack_q    <= ack_d;
            set_q    <= set_d;
        end
    end

    assign o_host_set_ack   = ack_q;
    assign o_time_stamp_sig = sig_q;
    assign o_time_stamp_set = set_q;
    assign o_sync_lock      = lock_q;
    assign o_pps_lost       = lost_q;
    assign o_glitch_cnt     = glitch_q;

endmodule
